// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel hobby-servo PWM from one shared frame counter.
// Ports: clk, rst_n (async, active-low); wr_en/wr_ch/wr_pos set a channel
// target; enable is a per-channel output enable latched at the frame boundary;
// servo are the PWM pins; frame_tick pulses at frame start; in_pos = cur==target.
// Optional: define SERVO_PWM_SLEW_EN to limit cur movement to SLEW_STEP per
// frame; otherwise cur jumps to target at each boundary.
module servo_pwm_multi #(
  parameter int N_CH        = 4,
  parameter int PERIOD_CLKS = 1000000,
  parameter int MIN_PULSE   = 50000,
  parameter int MAX_PULSE   = 100000,
  parameter int POS_W       = 16,
  parameter int SLEW_STEP   = 500,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [POS_W-1:0] wr_pos,
  input  logic [N_CH-1:0]  enable,
  output logic [N_CH-1:0]  servo,
  output logic             frame_tick,
  output logic [N_CH-1:0]  in_pos
);

  localparam int SPAN  = MAX_PULSE - MIN_PULSE;
  localparam int CNT_W = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam int CMP_W = ((CNT_W > POS_W) ? CNT_W : POS_W) + 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CLKS - 1);
  localparam logic [POS_W-1:0] SPAN_P   = POS_W'(SPAN);
  localparam logic [POS_W-1:0] MID_P    = POS_W'(SPAN / 2);
  localparam logic [CMP_W-1:0] MIN_C    = CMP_W'(MIN_PULSE);

  if (N_CH < 1 || N_CH > 16) begin : g_err_nch
    $error("servo_pwm_multi: N_CH must be 1..16");
  end
  if (MAX_PULSE >= PERIOD_CLKS) begin : g_err_max
    $error("servo_pwm_multi: MAX_PULSE must be below PERIOD_CLKS");
  end
  if (MIN_PULSE > MAX_PULSE) begin : g_err_min
    $error("servo_pwm_multi: MIN_PULSE exceeds MAX_PULSE");
  end
  if ((SPAN >> POS_W) != 0) begin : g_err_span
    $error("servo_pwm_multi: SPAN does not fit POS_W");
  end
  if (N_CH > 1 && CH_W < $clog2(N_CH)) begin : g_err_chw
    $error("servo_pwm_multi: CH_W too narrow for N_CH");
  end
  if (SLEW_STEP < 1) begin : g_err_slew
    $error("servo_pwm_multi: SLEW_STEP must be positive");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [POS_W-1:0] tgt_q [N_CH];
  logic [POS_W-1:0] cur_q [N_CH];
  logic [POS_W-1:0] cur_d [N_CH];
  logic [N_CH-1:0]  en_q;
  logic [N_CH-1:0]  servo_q;
  logic [N_CH-1:0]  servo_d;
  logic             tick_q;
  logic             boundary;
  logic [POS_W-1:0] wr_pos_c;

  assign boundary = (cnt_q == CNT_LAST);
  assign wr_pos_c = (wr_pos > SPAN_P) ? SPAN_P : wr_pos;

  // Widened compare so MIN_PULSE + cur never wraps.
  always_comb begin
    servo_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      servo_d[i] = en_q[i] &&
        ({{(CMP_W-CNT_W){1'b0}}, cnt_q} <
         (MIN_C + {{(CMP_W-POS_W){1'b0}}, cur_q[i]}));
    end
  end

`ifdef SERVO_PWM_SLEW_EN
  localparam int STEP_I = (SLEW_STEP > SPAN) ? SPAN : SLEW_STEP;
  localparam logic [POS_W-1:0] STEP = POS_W'(STEP_I);

  // Step toward target, landing exactly on it when closer than STEP.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cur_d[i] = cur_q[i];
      if (tgt_q[i] > cur_q[i]) begin
        cur_d[i] = ((tgt_q[i] - cur_q[i]) > STEP) ?
                   (cur_q[i] + STEP) : tgt_q[i];
      end else if (tgt_q[i] < cur_q[i]) begin
        cur_d[i] = ((cur_q[i] - tgt_q[i]) > STEP) ?
                   (cur_q[i] - STEP) : tgt_q[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cur_d[i] = tgt_q[i];
    end
  end
`endif

  always_comb begin
    in_pos = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_pos[i] = (cur_q[i] == tgt_q[i]);
    end
  end

  // Target writes land regardless of the boundary; cur_d was formed
  // from the old target, so a same-cycle write waits one more frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      en_q    <= '0;
      servo_q <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        tgt_q[i] <= MID_P;
        cur_q[i] <= MID_P;
      end
    end else begin
      cnt_q   <= boundary ? '0 : cnt_q + CNT_W'(1);
      tick_q  <= (cnt_q == '0);
      servo_q <= servo_d;
      if (boundary) begin
        en_q <= enable;
        for (int i = 0; i < N_CH; i++) begin
          cur_q[i] <= cur_d[i];
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        if (wr_en && (wr_ch == CH_W'(i))) begin
          tgt_q[i] <= wr_pos_c;
        end
      end
    end
  end

  assign servo      = servo_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: directed bench for servo_pwm_multi.
// 4 channels, 200-clk frame, 20..40 clk pulses, slew step 5.
module tb_servo_pwm_multi;

`ifdef SERVO_PWM_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_ch = '0;
  logic [15:0] wr_pos = '0;
  logic [3:0]  enable = 4'hF;
  logic [3:0]  servo;
  logic        frame_tick;
  logic [3:0]  in_pos;

  int checks = 0;
  int failures = 0;
  int w [4];
  int ticks;
  int waited;
  logic [3:0] ip0;
  logic [3:0] s0;

  servo_pwm_multi #(
    .N_CH(4),
    .PERIOD_CLKS(200),
    .MIN_PULSE(20),
    .MAX_PULSE(40),
    .POS_W(16),
    .SLEW_STEP(5),
    .CH_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_pos(wr_pos),
    .enable(enable),
    .servo(servo),
    .frame_tick(frame_tick),
    .in_pos(in_pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for a frame_tick sample, then samples one full 200-clk frame.
  // Optional mid-frame actions: enable change at sample en_k, one-cycle
  // write at sample wr_k. Sample k sees counter value (k+1) mod 200.
  task automatic measure(input int en_k, input logic [3:0] en_v,
                         input int wr_k, input logic [2:0] ch,
                         input logic [15:0] pos);
    waited = 0;
    while (frame_tick !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    assert (waited < 400) else begin
      failures++;
      $error("FAIL tick_wait observed=%0d expected=<400", waited);
    end
    ticks = 0;
    for (int c = 0; c < 4; c++) w[c] = 0;
    ip0 = in_pos;
    s0 = servo;
    for (int k = 0; k < 200; k++) begin
      if (frame_tick === 1'b1) ticks++;
      for (int c = 0; c < 4; c++) if (servo[c] === 1'b1) w[c]++;
      if (k == en_k) enable = en_v;
      if (k == wr_k) begin
        wr_en = 1'b1;
        wr_ch = ch;
        wr_pos = pos;
      end
      if (k == wr_k + 1) wr_en = 1'b0;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic frame(input string tag, input int e0, input int e1,
                       input int e2, input int e3, input logic [3:0] eip);
    int e [4];
    logic [3:0] es;
    e = '{e0, e1, e2, e3};
    es = {e3 > 0, e2 > 0, e1 > 0, e0 > 0};
    for (int c = 0; c < 4; c++)
      check($sformatf("%s_w%0d", tag, c), w[c], e[c]);
    check({tag, "_ticks"}, ticks, 1);
    check({tag, "_edge"}, {28'd0, s0}, {28'd0, es});
    check({tag, "_inpos"}, {28'd0, ip0}, {28'd0, eip});
  endtask

  task automatic do_write(input logic [2:0] ch, input logic [15:0] pos);
    wr_en = 1'b1;
    wr_ch = ch;
    wr_pos = pos;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_servo", {28'd0, servo}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    check("rst_inpos", {28'd0, in_pos}, 32'hF);
    rst_n = 1'b1;

    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    check("f1_wait", waited, 1);
    frame("f1", 0, 0, 0, 0, 4'hF);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    check("f2_wait", waited, 0);
    frame("f2", 30, 30, 30, 30, 4'hF);

    do_write(3'd1, 16'd20);
    check("wr1_inpos", {28'd0, in_pos}, 32'b1101);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    if (SLEW) frame("f4", 30, 35, 30, 30, 4'b1101);
    else      frame("f4", 30, 40, 30, 30, 4'hF);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    frame("f5", 30, 40, 30, 30, 4'hF);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    frame("f6", 30, 40, 30, 30, 4'hF);

    do_write(3'd2, 16'd50);
    do_write(3'd3, 16'd0);
    check("wr23_inpos", {28'd0, in_pos}, 32'b0011);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    if (SLEW) frame("f8", 30, 40, 35, 25, 4'b0011);
    else      frame("f8", 30, 40, 40, 20, 4'hF);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    frame("f9", 30, 40, 40, 20, 4'hF);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    frame("f10", 30, 40, 40, 20, 4'hF);

    measure(9, 4'hE, -1, 3'd0, 16'd0);
    frame("f11", 30, 40, 40, 20, 4'hF);
    measure(-1, 4'hE, -1, 3'd0, 16'd0);
    frame("f12", 0, 40, 40, 20, 4'hF);
    measure(9, 4'hF, -1, 3'd0, 16'd0);
    frame("f13", 0, 40, 40, 20, 4'hF);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    frame("f14", 30, 40, 40, 20, 4'hF);

    measure(-1, 4'hF, 198, 3'd0, 16'd0);
    frame("f15", 30, 40, 40, 20, 4'hF);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    frame("f16", 30, 40, 40, 20, 4'b1110);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    if (SLEW) frame("f17", 25, 40, 40, 20, 4'b1110);
    else      frame("f17", 20, 40, 40, 20, 4'hF);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    frame("f18", 20, 40, 40, 20, 4'hF);

    do_write(3'd5, 16'd0);
    check("wr5_inpos", {28'd0, in_pos}, 32'hF);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    frame("f20", 20, 40, 40, 20, 4'hF);

    repeat (5) @(negedge clk);
    check("pre_rst_servo", {28'd0, servo}, 32'hF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_servo", {28'd0, servo}, 32'd0);
    check("mid_rst_tick", {31'd0, frame_tick}, 32'd0);
    check("mid_rst_inpos", {28'd0, in_pos}, 32'hF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    check("r1_wait", waited, 1);
    frame("r1", 0, 0, 0, 0, 4'hF);
    measure(-1, 4'hF, -1, 3'd0, 16'd0);
    frame("r2", 30, 30, 30, 30, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
